// File: rtl/nxn_switch_allocator_if.sv
// Request/grant bundle between the input buffers, the switch allocator and the crossbar.
// The master side presents the front flits and the downstream ready; the slave side is the allocator.
interface nxn_switch_allocator_if #(
    parameter int IN_N      = 5,
    parameter int OUT_M     = 5,
    parameter int FLIT_ID_W = 2
);
    localparam int SEL_W = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int RT_W  = (OUT_M > 1) ? $clog2(OUT_M) : 1;

    logic [IN_N-1:0]           in_vld_i;
    logic [IN_N*FLIT_ID_W-1:0] in_flit_id_i;
    logic [IN_N*RT_W-1:0]      in_route_i;
    logic [OUT_M-1:0]          out_rdy_i;
    logic [OUT_M*SEL_W-1:0]    sel_o;
    logic [OUT_M-1:0]          out_vld_o;
    logic [IN_N-1:0]           in_rd_o;
    logic [OUT_M-1:0]          out_busy_o;

    modport master (
        output in_vld_i, in_flit_id_i, in_route_i, out_rdy_i,
        input  sel_o, out_vld_o, in_rd_o, out_busy_o
    );

    modport slave (
        input  in_vld_i, in_flit_id_i, in_route_i, out_rdy_i,
        output sel_o, out_vld_o, in_rd_o, out_busy_o
    );
endinterface

// File: rtl/nxn_switch_allocator.sv
// Wormhole switch allocator: one round-robin arbiter per output, locked from head flit to tail flit.
// Drives crossbar selects, per-output valids and per-input FIFO pop strobes.
module nxn_switch_allocator #(
    parameter int IN_N      = 5,
    parameter int OUT_M     = 5,
    parameter int FLIT_ID_W = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    nxn_switch_allocator_if.slave alloc
);
    localparam int SEL_W = (IN_N > 1) ? $clog2(IN_N) : 1;
    localparam int RT_W  = (OUT_M > 1) ? $clog2(OUT_M) : 1;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    logic [FLIT_ID_W-1:0] flit_id [IN_N];
    logic [RT_W-1:0]      route   [IN_N];
    logic [SEL_W-1:0]     owner_q [OUT_M];
    logic [IN_N-1:0]      eligible [OUT_M];
    logic [OUT_M-1:0]     busy_vec;
    logic [OUT_M-1:0]     out_vld;
    logic [OUT_M-1:0]     xfer;
    logic [IN_N-1:0]      owns;
    logic [IN_N-1:0]      in_rd;

    genvar gi;
    generate
        for (gi = 0; gi < IN_N; gi++) begin : g_in
            assign flit_id[gi] = alloc.in_flit_id_i[gi*FLIT_ID_W +: FLIT_ID_W];
            assign route[gi]   = alloc.in_route_i[gi*RT_W +: RT_W];
        end
    endgenerate

    // An input that already holds an output may not request another one.
    always_comb begin
        owns = '0;
        for (int m = 0; m < OUT_M; m++) begin
            for (int n = 0; n < IN_N; n++) begin
                if (busy_vec[m] && (owner_q[m] == SEL_W'(n))) begin
                    owns[n] = 1'b1;
                end
            end
        end
    end

    // Only head flits arbitrate; out-of-range routes never match any output.
    always_comb begin
        for (int m = 0; m < OUT_M; m++) begin
            eligible[m] = '0;
            for (int n = 0; n < IN_N; n++) begin
                eligible[m][n] = alloc.in_vld_i[n] && flit_id[n][1] &&
                                 (int'(route[n]) == m) && !owns[n];
            end
        end
    end

    assign xfer = out_vld & alloc.out_rdy_i & {OUT_M{~rst_i}};

    always_comb begin
        in_rd = '0;
        for (int n = 0; n < IN_N; n++) begin
            for (int m = 0; m < OUT_M; m++) begin
                if (xfer[m] && (owner_q[m] == SEL_W'(n))) begin
                    in_rd[n] = 1'b1;
                end
            end
        end
    end

    assign alloc.in_rd_o    = in_rd;
    assign alloc.out_vld_o  = out_vld;
    assign alloc.out_busy_o = busy_vec;

    generate
        for (gi = 0; gi < OUT_M; gi++) begin : g_out
            state_t           state_reg, state_next;
            logic [SEL_W-1:0] owner_reg, owner_next;
            logic [SEL_W-1:0] rr_ptr_reg, rr_ptr_next;
            logic             grant_vld;
            logic [SEL_W-1:0] grant_idx;
            int               idx;

            // First eligible input at or after the round-robin pointer.
            always_comb begin
                grant_vld = 1'b0;
                grant_idx = '0;
                idx       = 0;
                for (int i = 0; i < IN_N; i++) begin
                    idx = (int'(rr_ptr_reg) + i) % IN_N;
                    if (!grant_vld && eligible[gi][idx]) begin
                        grant_vld = 1'b1;
                        grant_idx = SEL_W'(idx);
                    end
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_reg  <= ST_IDLE;
                    owner_reg  <= '0;
                    rr_ptr_reg <= '0;
                end else begin
                    state_reg  <= state_next;
                    owner_reg  <= owner_next;
                    rr_ptr_reg <= rr_ptr_next;
                end
            end

            always_comb begin
                state_next  = state_reg;
                owner_next  = owner_reg;
                rr_ptr_next = rr_ptr_reg;
                case (state_reg)
                    ST_IDLE: begin
                        if (grant_vld) begin
                            state_next = ST_BUSY;
                            owner_next = grant_idx;
                        end
                    end
                    ST_BUSY: begin
                        // Tail (or single-flit) leaving releases the lock and moves priority past the owner.
                        if (xfer[gi] && flit_id[owner_reg][0]) begin
                            state_next  = ST_IDLE;
                            rr_ptr_next = (owner_reg == SEL_W'(IN_N - 1)) ? '0 : owner_reg + SEL_W'(1);
                        end
                    end
                    default: state_next = ST_IDLE;
                endcase
            end

            always_comb begin
                busy_vec[gi]                   = (state_reg == ST_BUSY);
                owner_q[gi]                    = owner_reg;
                out_vld[gi]                    = (state_reg == ST_BUSY) && alloc.in_vld_i[owner_reg];
                alloc.sel_o[gi*SEL_W +: SEL_W] = (state_reg == ST_BUSY) ? owner_reg : '0;
            end
        end
    endgenerate
endmodule

// File: tb/tb_nxn_switch_allocator.sv
// Bench for nxn_switch_allocator: vector table, directed packet scenarios and random traffic
// checked against a per-output lock/round-robin reference model.
module tb_nxn_switch_allocator;
    localparam int IN_N  = 5;
    localparam int OUT_M = 5;
    localparam int FW    = 2;
    localparam int QD    = 256;

    typedef logic [IN_N-1:0][1:0]  id_vec_t;
    typedef logic [IN_N-1:0][2:0]  rt_vec_t;
    typedef logic [OUT_M-1:0][2:0] sel_vec_t;

    typedef struct packed {
        logic             rst;
        logic [IN_N-1:0]  vld;
        id_vec_t          id;
        rt_vec_t          rt;
        logic [OUT_M-1:0] rdy;
        sel_vec_t         exp_sel;
        logic [OUT_M-1:0] exp_vld;
        logic [IN_N-1:0]  exp_rd;
        logic [OUT_M-1:0] exp_busy;
    } vec_t;

    typedef struct packed {
        logic [1:0] id;
        logic [2:0] route;
    } flit_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nxn_switch_allocator_if #(.IN_N(IN_N), .OUT_M(OUT_M), .FLIT_ID_W(FW)) bus();

    nxn_switch_allocator #(.IN_N(IN_N), .OUT_M(OUT_M), .FLIT_ID_W(FW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .alloc (bus)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    string scen = "init";

    vec_t  tbl [14];
    string tn  [14];

    flit_t fq     [IN_N][QD];
    int    fq_rd  [IN_N];
    int    fq_cnt [IN_N];

    int m_lock [OUT_M];
    int m_rr   [OUT_M];

    int               log_in  [OUT_M][64];
    int               log_cyc [OUT_M][64];
    int               log_cnt [OUT_M];
    logic [OUT_M-1:0] busy_log [64];

    logic [OUT_M-1:0] rdy_seq [$];
    bit               rst_seq [$];

    int s2_in  [9] = '{0, 0, 0, 1, 1, 1, 3, 3, 3};
    int s2_cyc [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
    int s4_cyc [4] = '{1, 3, 5, 6};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s %s: got 0x%0h expected 0x%0h", scen, nm, act, exp);
        end
    endtask

    task automatic fq_clear();
        for (int n = 0; n < IN_N; n++) begin
            fq_rd[n]  = 0;
            fq_cnt[n] = 0;
        end
    endtask

    task automatic push(input int n, input logic [1:0] id, input int route);
        fq[n][(fq_rd[n] + fq_cnt[n]) % QD] = '{id: id, route: 3'(route)};
        fq_cnt[n]++;
    endtask

    task automatic push_pkt(input int n, input int len, input int route);
        if (len == 1) begin
            push(n, 2'b11, route);
        end else begin
            push(n, 2'b10, route);
            for (int k = 0; k < len - 2; k++) push(n, 2'b00, $urandom_range(0, 7));
            push(n, 2'b01, $urandom_range(0, 7));
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < OUT_M; m++) begin
            m_lock[m] = -1;
            m_rr[m]   = 0;
        end
    endtask

    // Reference: each output either holds one input's packet or scans for the next head after its pointer.
    task automatic model_step(input logic r, input logic [IN_N-1:0] vld, input id_vec_t id,
                              input rt_vec_t rt, input logic [OUT_M-1:0] rdy,
                              output sel_vec_t e_sel, output logic [OUT_M-1:0] e_vld,
                              output logic [IN_N-1:0] e_rd, output logic [OUT_M-1:0] e_busy);
        int nlock [OUT_M];
        int nrr   [OUT_M];
        bit owned [IN_N];
        int o;
        int c;
        bit found;
        e_sel = '0; e_vld = '0; e_rd = '0; e_busy = '0;
        for (int n = 0; n < IN_N; n++) owned[n] = 1'b0;
        for (int m = 0; m < OUT_M; m++) if (m_lock[m] >= 0) owned[m_lock[m]] = 1'b1;
        for (int m = 0; m < OUT_M; m++) begin
            nlock[m] = m_lock[m];
            nrr[m]   = m_rr[m];
            if (m_lock[m] >= 0) begin
                o         = m_lock[m];
                e_busy[m] = 1'b1;
                e_sel[m]  = 3'(o);
                e_vld[m]  = vld[o];
                if (vld[o] && rdy[m] && !r) begin
                    e_rd[o] = 1'b1;
                    if (id[o][0]) begin
                        nlock[m] = -1;
                        nrr[m]   = (o + 1) % IN_N;
                    end
                end
            end else begin
                found = 1'b0;
                for (int k = 0; k < IN_N; k++) begin
                    c = (m_rr[m] + k) % IN_N;
                    if (!found && vld[c] && id[c][1] && (int'(rt[c]) == m) && !owned[c]) begin
                        found    = 1'b1;
                        nlock[m] = c;
                    end
                end
            end
        end
        for (int m = 0; m < OUT_M; m++) begin
            m_lock[m] = r ? -1 : nlock[m];
            m_rr[m]   = r ? 0 : nrr[m];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        bus.in_vld_i     = '0;
        bus.in_flit_id_i = '0;
        bus.in_route_i   = '0;
        bus.out_rdy_i    = '1;
        @(negedge clk);
        #1;
        check("reset_busy", 32'(bus.out_busy_o), 32'd0);
        check("reset_sel",  32'(bus.sel_o),      32'd0);
        check("reset_vld",  32'(bus.out_vld_o),  32'd0);
        check("reset_rd",   32'(bus.in_rd_o),    32'd0);
        model_reset();
        fq_clear();
    endtask

    // Drives front flits from the per-input queues, compares every cycle against the model, logs transfers.
    task automatic run(input int cycles, input bit rnd);
        id_vec_t          d_id;
        rt_vec_t          d_rt;
        logic [IN_N-1:0]  d_vld;
        logic [OUT_M-1:0] d_rdy;
        logic             d_rst;
        sel_vec_t         e_sel;
        sel_vec_t         a_sel;
        logic [OUT_M-1:0] e_vld;
        logic [OUT_M-1:0] e_busy;
        logic [IN_N-1:0]  e_rd;
        for (int m = 0; m < OUT_M; m++) begin
            log_cnt[m] = 0;
            for (int k = 0; k < 64; k++) begin
                log_in[m][k]  = -1;
                log_cyc[m][k] = -1;
            end
        end
        for (int k = 0; k < 64; k++) busy_log[k] = 'x;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (rnd) begin
                for (int n = 0; n < IN_N; n++)
                    if (fq_cnt[n] < 3) push_pkt(n, $urandom_range(1, 4), $urandom_range(0, OUT_M - 1));
            end
            d_vld = '0;
            for (int n = 0; n < IN_N; n++) begin
                if (fq_cnt[n] > 0 && (!rnd || $urandom_range(0, 4) != 0)) begin
                    d_vld[n] = 1'b1;
                    d_id[n]  = fq[n][fq_rd[n]].id;
                    d_rt[n]  = fq[n][fq_rd[n]].route;
                end else begin
                    d_id[n] = 2'($urandom_range(0, 3));
                    d_rt[n] = 3'($urandom_range(0, 7));
                end
            end
            d_rdy = (c < rdy_seq.size()) ? rdy_seq[c] : (rnd ? 5'($urandom) : 5'b11111);
            d_rst = (c < rst_seq.size()) ? rst_seq[c] : (rnd && ($urandom_range(0, 399) == 0));
            rst              = d_rst;
            bus.in_vld_i     = d_vld;
            bus.in_flit_id_i = d_id;
            bus.in_route_i   = d_rt;
            bus.out_rdy_i    = d_rdy;
            #1;
            model_step(d_rst, d_vld, d_id, d_rt, d_rdy, e_sel, e_vld, e_rd, e_busy);
            a_sel = bus.sel_o;
            check($sformatf("c%0d_busy", c), 32'(bus.out_busy_o), 32'(e_busy));
            check($sformatf("c%0d_sel", c),  32'(a_sel),          32'(e_sel));
            check($sformatf("c%0d_rd", c),   32'(bus.in_rd_o),    32'(e_rd));
            if (!d_rst) check($sformatf("c%0d_vld", c), 32'(bus.out_vld_o), 32'(e_vld));
            if (c < 64) busy_log[c] = bus.out_busy_o;
            for (int m = 0; m < OUT_M; m++) begin
                if (bus.out_vld_o[m] && d_rdy[m] && !d_rst && log_cnt[m] < 64) begin
                    log_in[m][log_cnt[m]]  = int'(a_sel[m]);
                    log_cyc[m][log_cnt[m]] = c;
                    log_cnt[m]++;
                end
            end
            for (int n = 0; n < IN_N; n++) begin
                if (bus.in_rd_o[n] && d_vld[n] && fq_cnt[n] > 0) begin
                    fq_rd[n] = (fq_rd[n] + 1) % QD;
                    fq_cnt[n]--;
                end
            end
            if (rnd && d_rst) fq_clear();
        end
    endtask

    task automatic fill_table();
        vec_t r;
        r = '0; r.vld = 5'b00100; r.id[2] = 2'b11; r.rt[2] = 3'd4; r.rdy = '1;
        tbl[0] = r; tn[0] = "arb_single";
        r.exp_sel[4] = 3'd2; r.exp_vld = 5'b10000; r.exp_rd = 5'b00100; r.exp_busy = 5'b10000;
        tbl[1] = r; tn[1] = "xfer_single";
        r = '0; r.rdy = '1;
        tbl[2] = r; tn[2] = "idle_after_tail";
        r.vld = 5'b01101; r.id[0] = 2'b11; r.id[2] = 2'b11; r.id[3] = 2'b11;
        r.rt[0] = 3'd4; r.rt[2] = 3'd4; r.rt[3] = 3'd4;
        tbl[3] = r; tn[3] = "arb_rr3";
        r.exp_sel[4] = 3'd3; r.exp_vld = 5'b10000; r.exp_rd = 5'b01000; r.exp_busy = 5'b10000;
        tbl[4] = r; tn[4] = "grant_rr3";
        r.vld = 5'b00101; r.exp_sel = '0; r.exp_vld = '0; r.exp_rd = '0; r.exp_busy = '0;
        tbl[5] = r; tn[5] = "arb_rr4";
        r.exp_sel[4] = 3'd0; r.exp_vld = 5'b10000; r.exp_rd = 5'b00001; r.exp_busy = 5'b10000;
        tbl[6] = r; tn[6] = "grant_wrap";
        r = '0; r.rdy = '1;
        tbl[7] = r; tn[7] = "bubble";
        r.vld = 5'b00010; r.id[1] = 2'b10; r.rt[1] = 3'd3;
        tbl[8] = r; tn[8] = "arb_head";
        r.rdy = 5'b10111; r.exp_sel[3] = 3'd1; r.exp_vld = 5'b01000; r.exp_busy = 5'b01000;
        tbl[9] = r; tn[9] = "rdy_low_hold";
        r.vld = '0; r.rdy = '1; r.exp_vld = '0;
        tbl[10] = r; tn[10] = "vld_drop_hold";
        r.vld = 5'b00010; r.exp_vld = 5'b01000; r.exp_rd = 5'b00010;
        tbl[11] = r; tn[11] = "head_xfer";
        r.id[1] = 2'b01; r.rt[1] = 3'd0;
        tbl[12] = r; tn[12] = "tail_xfer";
        r = '0; r.rdy = '1;
        tbl[13] = r; tn[13] = "released";
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_vld_i     = '0;
        bus.in_flit_id_i = '0;
        bus.in_route_i   = '0;
        bus.out_rdy_i    = '1;
        model_reset();
        fq_clear();

        scen = "table";
        fill_table();
        do_reset();
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            rst              = tbl[k].rst;
            bus.in_vld_i     = tbl[k].vld;
            bus.in_flit_id_i = tbl[k].id;
            bus.in_route_i   = tbl[k].rt;
            bus.out_rdy_i    = tbl[k].rdy;
            #1;
            check({tn[k], "_sel"},  32'(bus.sel_o),      32'(tbl[k].exp_sel));
            check({tn[k], "_vld"},  32'(bus.out_vld_o),  32'(tbl[k].exp_vld));
            check({tn[k], "_rd"},   32'(bus.in_rd_o),    32'(tbl[k].exp_rd));
            check({tn[k], "_busy"}, 32'(bus.out_busy_o), 32'(tbl[k].exp_busy));
            $display("vector %0d %s: busy=%b sel=%h rd=%b", k, tn[k], bus.out_busy_o, bus.sel_o, bus.in_rd_o);
        end

        scen = "three_pkts_out1";
        do_reset();
        rdy_seq.delete(); rst_seq.delete();
        push_pkt(0, 3, 1); push_pkt(1, 3, 1); push_pkt(3, 3, 1);
        run(16, 1'b0);
        check("xfer_count", 32'(log_cnt[1]), 32'd9);
        for (int k = 0; k < 9; k++) begin
            check($sformatf("owner%0d", k), 32'(log_in[1][k]),  32'(s2_in[k]));
            check($sformatf("cycle%0d", k), 32'(log_cyc[1][k]), 32'(s2_cyc[k]));
        end
        $display("scenario %s: %0d transfers on output 1", scen, log_cnt[1]);

        scen = "four_pairs";
        do_reset();
        push_pkt(0, 3, 1); push_pkt(1, 3, 2); push_pkt(2, 3, 3); push_pkt(3, 3, 0);
        run(6, 1'b0);
        check("busy_c0", 32'(busy_log[0]), 32'd0);
        check("busy_c1", 32'(busy_log[1]), 32'h0f);
        for (int m = 0; m < 4; m++) begin
            check($sformatf("out%0d_count", m), 32'(log_cnt[m]), 32'd3);
            check($sformatf("out%0d_owner", m), 32'(log_in[m][0]), 32'((m + 3) % 4));
            check($sformatf("out%0d_last", m),  32'(log_cyc[m][2]), 32'd3);
        end
        $display("scenario %s: busy at cycle 1 = %b", scen, busy_log[1]);

        scen = "ready_toggle";
        do_reset();
        rdy_seq = '{5'b11111, 5'b11111, 5'b11011, 5'b11111, 5'b11011, 5'b11111, 5'b11111};
        push_pkt(4, 4, 2);
        push(0, 2'b00, 2); push(0, 2'b00, 2); push(0, 2'b00, 2);
        run(10, 1'b0);
        rdy_seq.delete();
        check("xfer_count", 32'(log_cnt[2]), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("owner%0d", k), 32'(log_in[2][k]),  32'd4);
            check($sformatf("cycle%0d", k), 32'(log_cyc[2][k]), 32'(s4_cyc[k]));
        end
        check("body_never_popped", 32'(fq_cnt[0]), 32'd3);
        $display("scenario %s: %0d transfers on output 2", scen, log_cnt[2]);

        scen = "reset_mid_packet";
        do_reset();
        push_pkt(3, 1, 0);
        run(3, 1'b0);
        push(1, 2'b10, 0); push(1, 2'b00, 0); push(1, 2'b00, 0); push(1, 2'b01, 0);
        rst_seq = '{1'b0, 1'b0, 1'b0, 1'b1};
        run(5, 1'b0);
        rst_seq.delete();
        check("pre_reset_xfers", 32'(log_cnt[0]), 32'd2);
        check("left_in_fifo", 32'(fq_cnt[1]), 32'd2);
        check("busy_after_reset", 32'(busy_log[4]), 32'd0);
        fq_clear();
        push_pkt(2, 1, 0); push_pkt(4, 1, 0);
        run(5, 1'b0);
        check("fresh_first", 32'(log_in[0][0]), 32'd2);
        check("fresh_second", 32'(log_in[0][1]), 32'd4);
        check("fresh_cycle", 32'(log_cyc[0][1]), 32'd3);
        $display("scenario %s: first grant after reset to input %0d", scen, log_in[0][0]);

        scen = "bad_route";
        do_reset();
        push(0, 2'b11, 7);
        push_pkt(1, 1, 0);
        run(6, 1'b0);
        check("out0_count", 32'(log_cnt[0]), 32'd1);
        check("out0_owner", 32'(log_in[0][0]), 32'd1);
        check("in0_stalled", 32'(fq_cnt[0]), 32'd1);
        check("others_idle", 32'(log_cnt[1] + log_cnt[2] + log_cnt[3] + log_cnt[4]), 32'd0);
        $display("scenario %s: input 0 still holds %0d flit", scen, fq_cnt[0]);

        scen = "random";
        do_reset();
        run(3000, 1'b1);
        $display("scenario %s: done", scen);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
